// File: rtl/tx_fifo_writer_side.sv
// tx_fifo_writer_side: synchronous 9-bit FIFO from the RMAP reply builder
// (writer) to the SpaceWire link transmitter (reader).
// Ports: clk, rst (sync, active-high)
//   writer: writeEnable, dataIn[8:0], full
//   reader: readEnable, dataOut[8:0] (registered, 1-cycle latency), empty
//   status: usedWords[ADDR_W:0], overflowErr, underflowErr (sticky)
// Option: define TX_FIFO_PKT_GATE_EN to hold empty high until a complete
//   packet (EOP/EEP) is stored, or the FIFO is full.
module tx_fifo_writer_side #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              writeEnable,
    input  logic [DATA_W-1:0] dataIn,
    output logic              full,
    input  logic              readEnable,
    output logic [DATA_W-1:0] dataOut,
    output logic              empty,
    output logic [ADDR_W:0]   usedWords,
    output logic              overflowErr,
    output logic              underflowErr
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] PTR_ZERO = '0;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W:0]   wrPtr_q, wrPtr_d;
    logic [ADDR_W:0]   rdPtr_q, rdPtr_d;
    logic [ADDR_W:0]   used_d;
    logic [DATA_W-1:0] dataOut_q, dataOut_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              writeAcc, readAcc;
    logic [DATA_W-1:0] rdWord;

    assign rdWord = mem_q[rdPtr_q[ADDR_W-1:0]];

`ifdef TX_FIFO_PKT_GATE_EN
    logic [ADDR_W:0] pktCnt_q, pktCnt_d;
    logic            pktInc, pktDec;
`endif

    always_comb begin
        writeAcc  = writeEnable & ~full_q;
        readAcc   = readEnable & ~empty_q;
        wrPtr_d   = writeAcc ? wrPtr_q + PTR_ONE : wrPtr_q;
        rdPtr_d   = readAcc ? rdPtr_q + PTR_ONE : rdPtr_q;
        dataOut_d = readAcc ? rdWord : dataOut_q;
        ovf_d     = ovf_q | (writeEnable & full_q);
        unf_d     = unf_q | (readEnable & empty_q);
        // Extra pointer MSB makes full (diff == DEPTH) distinct from empty.
        used_d    = wrPtr_d - rdPtr_d;
        full_d    = (used_d == DEPTH_V);
`ifdef TX_FIFO_PKT_GATE_EN
        pktInc    = writeAcc & dataIn[DATA_W-1];
        pktDec    = readAcc & rdWord[DATA_W-1];
        pktCnt_d  = pktCnt_q;
        if (pktInc & ~pktDec) begin
            pktCnt_d = pktCnt_q + PTR_ONE;
        end else if (pktDec & ~pktInc) begin
            pktCnt_d = pktCnt_q - PTR_ONE;
        end
        // Hide partial packets, except when full with no terminator
        // stored: then the oversize packet must be allowed to drain.
        empty_d   = (used_d == PTR_ZERO) | ((pktCnt_d == PTR_ZERO) & ~full_d);
`else
        empty_d   = (used_d == PTR_ZERO);
`endif
    end

    always_ff @(posedge clk) begin
        if (writeAcc) begin
            mem_q[wrPtr_q[ADDR_W-1:0]] <= dataIn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            dataOut_q <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            dataOut_q <= dataOut_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

`ifdef TX_FIFO_PKT_GATE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pktCnt_q <= '0;
        end else begin
            pktCnt_q <= pktCnt_d;
        end
    end
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign dataOut      = dataOut_q;
    assign usedWords    = wrPtr_q - rdPtr_q;
    assign overflowErr  = ovf_q;
    assign underflowErr = unf_q;

endmodule
